// File: rtl/preg_freelist_pkg.sv
// Shared types and sizes for the physical-register free list.
//   PREG_SIZE / LREG_SIZE : physical / logical register counts
//   NF                    : free-list depth (pregs not architecturally mapped at reset)
//   FL_PTR_W              : free-list pointer width, index bits plus one wrap bit
//   rob_state_e           : ROB recovery state as seen by rename
package preg_freelist_pkg;
  localparam int PREG_SIZE = 64;
  localparam int LREG_SIZE = 32;
  localparam int NF        = PREG_SIZE - LREG_SIZE;
  localparam int PREG_W    = $clog2(PREG_SIZE);
  localparam int FL_IDX_W  = $clog2(NF);
  localparam int FL_PTR_W  = FL_IDX_W + 1;

  typedef logic [PREG_W-1:0]   preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;

  typedef enum logic [1:0] {
    ROB_STATE_IDLE          = 2'd0,
    ROB_STATE_OVERWRITE_RAT = 2'd1,
    ROB_STATE_WALKING       = 2'd2
  } rob_state_e;

  // Number of asserted bits in a two-slot valid pair.
  function automatic logic [1:0] pop2(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction
endpackage

// File: rtl/preg_freelist_if.sv
// Rename/commit/ROB-facing bundle of the physical-register free list.
//   master : rename/ROB side (drives requests, commits, recovery state)
//   slave  : free list (returns ready, granted pregs, free count)
interface preg_freelist_if;
  import preg_freelist_pkg::*;

  logic       alloc_req0;
  logic       alloc_req1;
  logic       alloc_ready;
  preg_t      alloc_preg0;
  preg_t      alloc_preg1;
  logic       commit_en0;
  logic       commit_en1;
  preg_t      commit_old_prd0;
  preg_t      commit_old_prd1;
  rob_state_e rob_state;
  logic       rob_walk0_valid;
  logic       rob_walk1_valid;
  fl_ptr_t    free_count;

  modport master (
    output alloc_req0, alloc_req1, commit_en0, commit_en1,
           commit_old_prd0, commit_old_prd1, rob_state,
           rob_walk0_valid, rob_walk1_valid,
    input  alloc_ready, alloc_preg0, alloc_preg1, free_count
  );

  modport slave (
    input  alloc_req0, alloc_req1, commit_en0, commit_en1,
           commit_old_prd0, commit_old_prd1, rob_state,
           rob_walk0_valid, rob_walk1_valid,
    output alloc_ready, alloc_preg0, alloc_preg1, free_count
  );
endinterface

// File: rtl/preg_freelist_ptr.sv
// Wrapping free-list pointer: steps by +0..2 and -0..2 per cycle, or loads a value.
//   clock, reset_n : clock, async active-low reset (pointer -> RESET_VAL)
//   inc, dec       : step amounts applied together this cycle
//   load_en/val    : overrides stepping with load_val
//   ptr_q          : current pointer
//   ptr_d          : next pointer (exposed so other pointers can track it same-cycle)
module preg_freelist_ptr
  import preg_freelist_pkg::*;
#(
  parameter int RESET_VAL = 0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] inc,
  input  logic [1:0] dec,
  input  logic       load_en,
  input  fl_ptr_t    load_val,
  output fl_ptr_t    ptr_q,
  output fl_ptr_t    ptr_d
);
  // NF is a power of two, so the wrap bit is simply the carry out of the index
  // bits and plain modular add/subtract gives correct wrapping in both directions.
  always_comb begin
    ptr_d = ptr_q;
    if (load_en) ptr_d = load_val;
    else         ptr_d = ptr_q + FL_PTR_W'(inc) - FL_PTR_W'(dec);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= FL_PTR_W'(RESET_VAL);
    else          ptr_q <= ptr_d;
  end
endmodule

// File: rtl/preg_freelist.sv
// Physical-register free list: circular FIFO of free preg numbers with a
// speculative head (rename), committed head (arch_head) and tail (commit frees).
//   clock, reset_n : clock, async active-low reset
//   fl             : rename/commit/ROB bundle (slave side)
//   err_overflow / err_underflow : sticky error flags, present only with
//                    FREELIST_ERR_CHECK_EN defined
module preg_freelist
  import preg_freelist_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  preg_freelist_if.slave fl
`ifdef FREELIST_ERR_CHECK_EN
  ,
  output logic           err_overflow,
  output logic           err_underflow
`endif
);
  preg_t   entries_q [NF];
  preg_t   entries_d [NF];
  fl_ptr_t head_q, head_d, arch_head_q, arch_head_d, tail_q, tail_d;
  fl_ptr_t free_count_q, free_count_d, count;
  logic [1:0] need_n, commit_n, walk_n, head_inc, head_dec;
  logic is_idle, is_walking, is_overwrite, fire;
  logic [FL_IDX_W-1:0] head_idx, head1_idx, tail_idx, tail1_idx;

  // Ready is based on registered occupancy only: same-cycle frees are not bypassed.
  assign count        = tail_q - head_q;
  assign need_n       = pop2(fl.alloc_req0, fl.alloc_req1);
  assign commit_n     = pop2(fl.commit_en0, fl.commit_en1);
  assign walk_n       = pop2(fl.rob_walk0_valid, fl.rob_walk1_valid);
  assign is_idle      = (fl.rob_state == ROB_STATE_IDLE);
  assign is_walking   = (fl.rob_state == ROB_STATE_WALKING);
  assign is_overwrite = (fl.rob_state == ROB_STATE_OVERWRITE_RAT);

  assign fl.alloc_ready = (count >= FL_PTR_W'(need_n)) && is_idle;
  assign fire           = fl.alloc_ready && (fl.alloc_req0 || fl.alloc_req1);
  assign head_inc       = fire ? need_n : 2'd0;
  assign head_dec       = is_walking ? walk_n : 2'd0;

  assign head_idx  = head_q[FL_IDX_W-1:0];
  assign head1_idx = head_idx + FL_IDX_W'(1);
  assign tail_idx  = tail_q[FL_IDX_W-1:0];
  assign tail1_idx = tail_idx + FL_IDX_W'(1);

  // Slot 1 takes the first free entry when slot 0 is not allocating.
  assign fl.alloc_preg0 = entries_q[head_idx];
  assign fl.alloc_preg1 = fl.alloc_req0 ? entries_q[head1_idx] : entries_q[head_idx];
  assign fl.free_count  = free_count_q;

  preg_freelist_ptr #(.RESET_VAL(NF)) u_tail (
    .clock(clock), .reset_n(reset_n), .inc(commit_n), .dec(2'd0),
    .load_en(1'b0), .load_val('0), .ptr_q(tail_q), .ptr_d(tail_d)
  );

  preg_freelist_ptr #(.RESET_VAL(0)) u_arch_head (
    .clock(clock), .reset_n(reset_n), .inc(commit_n), .dec(2'd0),
    .load_en(1'b0), .load_val('0), .ptr_q(arch_head_q), .ptr_d(arch_head_d)
  );

  // Overwrite recovery snaps head to the committed head including this cycle's commits.
  preg_freelist_ptr #(.RESET_VAL(0)) u_head (
    .clock(clock), .reset_n(reset_n), .inc(head_inc), .dec(head_dec),
    .load_en(is_overwrite), .load_val(arch_head_d), .ptr_q(head_q), .ptr_d(head_d)
  );

  always_comb begin
    entries_d = entries_q;
    if (fl.commit_en0) entries_d[tail_idx] = fl.commit_old_prd0;
    if (fl.commit_en1) entries_d[fl.commit_en0 ? tail1_idx : tail_idx] = fl.commit_old_prd1;
    free_count_d = tail_d - head_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NF; i++) entries_q[i] <= PREG_W'(LREG_SIZE + i);
      free_count_q <= FL_PTR_W'(NF);
    end else begin
      entries_q    <= entries_d;
      free_count_q <= free_count_d;
    end
  end

`ifdef FREELIST_ERR_CHECK_EN
  logic err_overflow_q, err_overflow_d, err_underflow_q, err_underflow_d;
  fl_ptr_t spec_depth;

  // Distance from committed head to speculative head = pregs a walk may return.
  assign spec_depth = head_q - arch_head_q;

  always_comb begin
    err_overflow_d  = err_overflow_q  | ((int'(count) + int'(commit_n)) > NF);
    err_underflow_d = err_underflow_q | (is_walking && (int'(spec_depth) < int'(walk_n)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      err_overflow_q  <= err_overflow_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_overflow  = err_overflow_q;
  assign err_underflow = err_underflow_q;
`endif
endmodule
